// File: rtl/vga_timing_gen.sv
//------------------------------------------------------------------------------
// vga_timing_gen : 640x480@60 raster counters with registered blank/sync/frame decode.
// Optional macro VGA_SYNC_ALIGN_EN delays hs/vs by one extra register stage.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_TOTAL   = 800,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_TOTAL   = 525
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       frame_start
);

    localparam logic [9:0] c_H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] c_H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] c_V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] c_HS_FIRST = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] c_HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] c_VS_FIRST = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] c_VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       blank_q, blank_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       fs_q, fs_d;

    // Flags decode the next counter values so they line up with DrawX/DrawY.
    always_comb begin
        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
        if (hc_q == c_H_LAST) begin
            hc_d = 10'd0;
            vc_d = (vc_q == c_V_LAST) ? 10'd0 : vc_q + 10'd1;
        end
        blank_d = (hc_d < c_H_VIS) && (vc_d < c_V_VIS);
        hs_d    = !((hc_d >= c_HS_FIRST) && (hc_d <= c_HS_LAST));
        vs_d    = !((vc_d >= c_VS_FIRST) && (vc_d <= c_VS_LAST));
        fs_d    = (hc_d == 10'd0) && (vc_d == 10'd0);
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hc_q    <= c_H_LAST;
            vc_q    <= c_V_LAST;
            blank_q <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            blank_q <= blank_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            fs_q    <= fs_d;
        end
    end

    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign blank       = blank_q;
    assign frame_start = fs_q;

`ifdef VGA_SYNC_ALIGN_EN
    logic hs_al_q;
    logic vs_al_q;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hs_al_q <= 1'b1;
            vs_al_q <= 1'b1;
        end else begin
            hs_al_q <= hs_q;
            vs_al_q <= vs_q;
        end
    end

    assign hs = hs_al_q;
    assign vs = vs_al_q;
`else
    assign hs = hs_q;
    assign vs = vs_q;
`endif

endmodule

`default_nettype wire
